// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared command codes, FSM states and default sizes for fma_seq
package fma_pkg;

  localparam int NLANE_DEF = 4;
  localparam int DEPTH_DEF = 5;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_FMA   = 2'd1,
    CMD_ACC   = 2'd2,
    CMD_FLUSH = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  // Width of a lane index; at least one bit so single-lane builds stay legal.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fma_seq_pipe.sv
// rtl/fma_seq_pipe.sv - valid/command/lane stage shift register with ACC lane hazard compare
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   issue_vld_i         an operation enters stage 1 on the next edge
//   issue_cmd_i         2-bit command of the entering operation
//   issue_lane_i        lane of the entering operation (already reduced mod NLANE)
//   chk_lane_i          lane of the incoming request, compared against ACCs in stages 1-3
//   hazard_o            an ACC to chk_lane_i is in stages 1-3
//   empty_front_o       stages 1-4 hold nothing
//   empty_all_o         no stage holds anything
//   mul_en_o .. rslt_cmd_o  per-stage enables and retiring command
module fma_seq_pipe
  import fma_pkg::*;
#(
  parameter int NLANE = NLANE_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int LW   = lane_bits(NLANE)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             issue_vld_i,
  input  logic [1:0]       issue_cmd_i,
  input  logic [LW-1:0]    issue_lane_i,
  input  logic [LW-1:0]    chk_lane_i,
  output logic             hazard_o,
  output logic             empty_front_o,
  output logic             empty_all_o,
  output logic             mul_en_o,
  output logic             asft_en0_o,
  output logic [NLANE-1:0] asft_en1_o,
  output logic             add_en_o,
  output logic             rslt_vld_o,
  output logic [1:0]       rslt_cmd_o
);

  logic [DEPTH:1]          vld_q, vld_d;
  logic [DEPTH:1][1:0]     cmd_q, cmd_d;
  // Lane is only consumed up to the shift stage, so it is not carried further.
  logic [3:1][LW-1:0]      lane_q, lane_d;

  always_comb begin
    vld_d  = {vld_q[DEPTH-1:1], issue_vld_i};
    // Empty slots carry NOP so the retiring command is clean when nothing retires.
    cmd_d  = {cmd_q[DEPTH-1:1], (issue_vld_i ? issue_cmd_i : CMD_NOP)};
    lane_d = {lane_q[2:1], issue_lane_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q  <= '0;
      cmd_q  <= '0;
      lane_q <= '0;
    end else begin
      vld_q  <= vld_d;
      cmd_q  <= cmd_d;
      lane_q <= lane_d;
    end
  end

  // A second ACC to the same lane must wait until the first has written its
  // accumulator in the shift stage.
  always_comb begin
    hazard_o = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (vld_q[k] && (cmd_q[k] == CMD_ACC) && (lane_q[k] == chk_lane_i)) begin
        hazard_o = 1'b1;
      end
    end
  end

  always_comb begin
    asft_en1_o = '0;
    if (vld_q[3] && ((cmd_q[3] == CMD_ACC) || (cmd_q[3] == CMD_FLUSH))) begin
      asft_en1_o[lane_q[3]] = 1'b1;
    end
  end

  assign empty_front_o = ~|vld_q[4:1];
  assign empty_all_o   = ~|vld_q;
  assign mul_en_o      = vld_q[1];
  assign asft_en0_o    = vld_q[2];
  assign add_en_o      = vld_q[4];
  assign rslt_vld_o    = vld_q[DEPTH];
  assign rslt_cmd_o    = cmd_q[DEPTH];

endmodule

// File: rtl/fma_seq.sv
// rtl/fma_seq.sv - FMA/accumulate issue sequencer with lane hazard stall and lane flush
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, req_command    request valid and 32-bit op code (0 NOP, 1 FMA, 2 ACC, 3 FLUSH)
//   req_lane            accumulator lane for ACC (taken mod NLANE)
//   ready               request accepted this cycle when req & ready
//   mul_en, asft_en0, asft_en1, add_en   stage enables
//   rslt_vld, rslt_cmd  retiring operation and its command
//   busy                work in flight or sequencer not idle
module fma_seq
  import fma_pkg::*;
#(
  parameter int NLANE = NLANE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [31:0]      req_command,
  input  logic [1:0]       req_lane,
  output logic             ready,
  output logic             mul_en,
  output logic             asft_en0,
  output logic [NLANE-1:0] asft_en1,
  output logic             add_en,
  output logic             rslt_vld,
  output logic [31:0]      rslt_cmd,
  output logic             busy
);

  localparam int            LW        = lane_bits(NLANE);
  localparam logic [LW-1:0] LAST_LANE = LW'(NLANE - 1);

  state_t        state_q;
  logic [LW-1:0] cnt_q;

  logic          is_fma, is_acc, is_flush, is_op, accept;
  logic [LW-1:0] lane_w;
  logic          hazard, empty_front, empty_all;
  logic          issue_vld;
  logic [1:0]    issue_cmd;
  logic [LW-1:0] issue_lane;
  logic [1:0]    rslt_cmd2;

  assign lane_w   = LW'(32'(req_lane) % 32'(NLANE));
  assign is_fma   = (req_command == {30'd0, CMD_FMA});
  assign is_acc   = (req_command == {30'd0, CMD_ACC});
  assign is_flush = (req_command == {30'd0, CMD_FLUSH});
  assign is_op    = is_fma || is_acc;

  // NOPs and unknown codes are accepted like anything else but never issue.
  assign ready  = !reset && ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !(is_acc && hazard);
  assign accept = req && ready;

  always_comb begin
    issue_vld  = 1'b0;
    issue_cmd  = CMD_NOP;
    issue_lane = '0;
    if (state_q == ST_FLUSH) begin
      issue_vld  = 1'b1;
      issue_cmd  = CMD_FLUSH;
      issue_lane = cnt_q;
    end else if (accept && is_op) begin
      issue_vld  = 1'b1;
      issue_cmd  = req_command[1:0];
      issue_lane = lane_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          // The FLUSH request itself never enters the pipe; only its per-lane issues do.
          if (accept && is_flush) begin
            state_q <= ST_DRAIN;
          end else if (accept && is_op) begin
            state_q <= ST_RUN;
          end else if (empty_all) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (empty_front) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
          end
        end
        ST_FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_LANE) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fma_seq_pipe #(
    .NLANE(NLANE),
    .DEPTH(DEPTH)
  ) u_pipe (
    .clk_i         (clk),
    .reset_i       (reset),
    .issue_vld_i   (issue_vld),
    .issue_cmd_i   (issue_cmd),
    .issue_lane_i  (issue_lane),
    .chk_lane_i    (lane_w),
    .hazard_o      (hazard),
    .empty_front_o (empty_front),
    .empty_all_o   (empty_all),
    .mul_en_o      (mul_en),
    .asft_en0_o    (asft_en0),
    .asft_en1_o    (asft_en1),
    .add_en_o      (add_en),
    .rslt_vld_o    (rslt_vld),
    .rslt_cmd_o    (rslt_cmd2)
  );

  assign rslt_cmd = {30'd0, rslt_cmd2};
  assign busy     = (state_q != ST_IDLE) || !empty_all;

endmodule

// File: tb/tb_fma_seq.sv
// tb/tb_fma_seq.sv - self-checking bench for fma_seq against a cycle-schedule reference model
module tb_fma_seq;

  localparam int NL   = 4;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [31:0]   req_command;
  logic [1:0]    req_lane;
  logic          ready, mul_en, asft_en0, add_en, rslt_vld, busy;
  logic [NL-1:0] asft_en1;
  logic [31:0]   rslt_cmd;

  fma_seq #(.NLANE(NL), .DEPTH(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_command (req_command),
    .req_lane    (req_lane),
    .ready       (ready),
    .mul_en      (mul_en),
    .asft_en0    (asft_en0),
    .asft_en1    (asft_en1),
    .add_en      (add_en),
    .rslt_vld    (rslt_vld),
    .rslt_cmd    (rslt_cmd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Expected outputs per absolute cycle, filled in when an operation is accepted.
  bit            e_mul  [MAXC];
  bit            e_a0   [MAXC];
  bit            e_add  [MAXC];
  bit            e_rv   [MAXC];
  bit            e_busy [MAXC];
  logic [NL-1:0] e_en1  [MAXC];
  int            e_rcmd [MAXC];

  int blocked_until = -1;
  int last_issue    = -100;
  typedef struct { int t; int lane; } acc_t;
  acc_t accq[$];

  int   rv3_cnt = 0;
  logic last_dut_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Operation issued into stage 1 on the edge closing cycle i.
  task automatic schedule(input int i, input int cmd, input int lane);
    e_mul[i+1] = 1'b1;
    e_a0[i+2]  = 1'b1;
    if (cmd == 2 || cmd == 3) e_en1[i+3][lane] = 1'b1;
    e_add[i+4]  = 1'b1;
    e_rv[i+5]   = 1'b1;
    e_rcmd[i+5] = cmd;
    // Sequencer falls back to idle one cycle after the pipe empties.
    for (int k = i + 1; k <= i + 6; k++) e_busy[k] = 1'b1;
    if (i > last_issue) last_issue = i;
    if (cmd == 2) accq.push_back('{i, lane});
  endtask

  function automatic bit model_ready(input int c, input int cmd, input int lane);
    if (c <= blocked_until) return 1'b0;
    if (cmd == 2) begin
      foreach (accq[k]) begin
        if (accq[k].lane == lane && (c - accq[k].t) >= 1 && (c - accq[k].t) <= 3) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic step(input bit rst, input bit r, input int cmd, input int lane, output bit acc);
    bit rm;
    int f0, d;
    reset       = rst;
    req         = r;
    req_command = cmd;
    req_lane    = lane[1:0];
    @(negedge clk);
    acc = 1'b0;
    last_dut_ready = ready;
    if (rst) begin
      check("ready_in_reset", 32'(ready), 32'(1'b0));
    end else begin
      rm = model_ready(cyc, cmd, lane % NL);
      check("ready",    32'(ready),    32'(rm));
      check("mul_en",   32'(mul_en),   32'(e_mul[cyc]));
      check("asft_en0", 32'(asft_en0), 32'(e_a0[cyc]));
      check("asft_en1", 32'(asft_en1), 32'(e_en1[cyc]));
      check("add_en",   32'(add_en),   32'(e_add[cyc]));
      check("rslt_vld", 32'(rslt_vld), 32'(e_rv[cyc]));
      check("busy",     32'(busy),     32'(e_busy[cyc]));
      if (e_rv[cyc]) check("rslt_cmd", rslt_cmd, 32'(e_rcmd[cyc]));
      if (rslt_vld === 1'b1 && rslt_cmd === 32'd3) rv3_cnt++;
      acc = r && rm;
      if (acc) begin
        if (cmd == 1 || cmd == 2) begin
          schedule(cyc, cmd, lane % NL);
        end else if (cmd == 3) begin
          // Drain until stages 1-4 are clear, then one issue per lane.
          d  = (cyc + 1 > last_issue + 5) ? cyc + 1 : last_issue + 5;
          f0 = d + 1;
          for (int k = cyc + 1; k <= f0; k++) e_busy[k] = 1'b1;
          for (int j = 0; j < NL; j++) schedule(f0 + j, 3, j);
          blocked_until = f0 + NL - 1;
        end
      end
    end
    if (rst) begin
      for (int k = cyc + 1; k < MAXC; k++) begin
        e_mul[k] = 0; e_a0[k] = 0; e_add[k] = 0; e_rv[k] = 0;
        e_busy[k] = 0; e_en1[k] = '0; e_rcmd[k] = 0;
      end
      accq.delete();
      blocked_until = -1;
      last_issue    = -100;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, a);
  endtask

  initial begin
    bit a;
    int dut_blk;
    int tries;
    int pc, pl;
    bit pend;

    for (int k = 0; k < MAXC; k++) begin
      e_mul[k] = 0; e_a0[k] = 0; e_add[k] = 0; e_rv[k] = 0;
      e_busy[k] = 0; e_en1[k] = '0; e_rcmd[k] = 0;
    end
    reset = 1'b1; req = 1'b0; req_command = '0; req_lane = '0;
    @(posedge clk);
    #1;

    step(1'b1, 1'b0, 0, 0, a);
    step(1'b1, 1'b0, 0, 0, a);
    idle(2);

    // Single FMA
    step(1'b0, 1'b1, 1, 0, a);
    idle(8);

    // Unknown command: accepted, no activity
    step(1'b0, 1'b1, 7, 1, a);
    idle(6);

    // Same-lane ACC pair: second is held until the first clears stage 3
    step(1'b0, 1'b1, 2, 2, a);
    dut_blk = 0;
    tries   = 0;
    a       = 1'b0;
    while (!a && tries < 10) begin
      step(1'b0, 1'b1, 2, 2, a);
      if (last_dut_ready !== 1'b1) dut_blk++;
      tries++;
    end
    check("acc_hazard_stall_cycles", 32'(dut_blk), 32'd3);
    idle(8);

    // ACC to lanes 0..3 back-to-back
    for (int l = 0; l < 4; l++) step(1'b0, 1'b1, 2, l, a);
    idle(8);

    // FMA followed by FLUSH
    rv3_cnt = 0;
    step(1'b0, 1'b1, 1, 0, a);
    step(1'b0, 1'b1, 3, 0, a);
    idle(20);
    check("flush_pulse_count", 32'(rv3_cnt), 32'd4);

    // Reset in the middle of a flush
    step(1'b0, 1'b1, 3, 0, a);
    idle(3);
    step(1'b1, 1'b0, 0, 0, a);
    rv3_cnt = 0;
    idle(15);
    check("pulses_after_reset", 32'(rv3_cnt), 32'd0);

    // Random traffic; a refused request is held until taken
    pend = 1'b0;
    pc = 0;
    pl = 0;
    for (int n = 0; n < 500; n++) begin
      bit rst, r;
      int cmd, lane;
      rst = ($urandom_range(0, 99) == 0);
      if (pend) begin
        r = 1'b1; cmd = pc; lane = pl;
      end else begin
        r = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 19))
          0:                cmd = 3;
          1:                cmd = 0;
          2:                cmd = int'($urandom_range(4, 255));
          3, 4, 5, 6, 7, 8: cmd = 1;
          default:          cmd = 2;
        endcase
        lane = int'($urandom_range(0, 3));
      end
      step(rst, r, cmd, lane, a);
      pend = r && !a && !rst;
      pc = cmd;
      pl = lane;
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
